// File: rtl/pacman_pkg.sv
// pacman_pkg: maze geometry, scoring constants and tile helpers shared by the maze-map blocks.
package pacman_pkg;
  localparam int MAZE_ROWS = 31;
  localparam int MAZE_COLS = 28;
  localparam int DOT_POINTS = 10;
  localparam int PELLET_POINTS = 50;
  typedef struct packed {
    logic [4:0] row;
    logic [4:0] col;
  } tile_t;
  typedef enum logic [1:0] {INIT_ADDR, INIT_SCAN, RUN, CLEARED} eater_state_t;
  localparam tile_t LAST_TILE = '{row: 5'(MAZE_ROWS - 1), col: 5'(MAZE_COLS - 1)};
  function automatic logic is_pellet_tile(tile_t t);
    return (t.row == 5'd3 || t.row == 5'd23) && (t.col == 5'd1 || t.col == 5'd26);
  endfunction
  function automatic logic in_maze(tile_t t);
    return t.row < 5'(MAZE_ROWS) && t.col < 5'(MAZE_COLS);
  endfunction
endpackage

// File: rtl/dot_init_scan.sv
// dot_init_scan: row-major maze address walker with a one-cycle-delayed write address and done flag.
module dot_init_scan
  import pacman_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr,
  input  logic       en,
  output logic [4:0] rd_row,
  output logic [4:0] rd_col,
  output logic [4:0] wr_row,
  output logic [4:0] wr_col,
  output logic       wr_en,
  output logic       done
);
  tile_t rd_q, rd_d, wr_q, wr_d, rd_next;
  logic rv_q, rv_d, wv_q, wv_d, last;
  assign last = rd_q == LAST_TILE;
  assign rd_next = rd_q.col == 5'(MAZE_COLS - 1) ? tile_t'{row: rd_q.row + 5'd1, col: 5'd0}
                                                : tile_t'{row: rd_q.row, col: rd_q.col + 5'd1};
  always_comb begin
    rd_d = rd_q;
    rv_d = rv_q;
    wr_d = wr_q;
    wv_d = wv_q;
    if (clr) begin
      rd_d = '0;
      rv_d = 1'b1;
      wv_d = 1'b0;
    end else if (en) begin
      wr_d = rd_q;
      wv_d = rv_q;
      rv_d = rv_q && !last;
      rd_d = last ? rd_q : rd_next;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_q <= '0;
      rv_q <= 1'b1;
      wr_q <= '0;
      wv_q <= 1'b0;
    end else begin
      rd_q <= rd_d;
      rv_q <= rv_d;
      wr_q <= wr_d;
      wv_q <= wv_d;
    end
  end
  assign rd_row = rd_q.row;
  assign rd_col = rd_q.col;
  assign wr_row = wr_q.row;
  assign wr_col = wr_q.col;
  assign wr_en = wv_q;
  assign done = wv_q && wr_q == LAST_TILE;
endmodule

// File: rtl/dot_eater.sv
// dot_eater: sole owner of the live dot map; builds it from the wall ROM, then clears tiles as they are eaten.
module dot_eater
  import pacman_pkg::*;
#(
  parameter int SCORE_W = 20
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               new_level,
  input  logic               pac_valid,
  input  logic [4:0]         pac_row,
  input  logic [4:0]         pac_col,
  output logic [4:0]         wall_row,
  output logic [4:0]         wall_col,
  input  logic               wall_is_wall,
  input  logic [4:0]         disp_row,
  input  logic [4:0]         disp_col,
  output logic               disp_dot,
  output logic               disp_pellet,
  output logic               ready,
  output logic               dot_eaten,
  output logic               pellet_eaten,
  output logic               level_clear,
  output logic [SCORE_W-1:0] score,
  output logic [9:0]         dots_left
);
  eater_state_t state_q, state_d;
  logic [MAZE_COLS-1:0] map_q [MAZE_ROWS];
  logic [MAZE_COLS-1:0] map_d [MAZE_ROWS];
  logic [SCORE_W-1:0] score_q, score_d;
  logic [9:0] dots_q, dots_d;
  logic dot_q, dot_d, pel_q, pel_d, clr_q, clr_d;
  logic [4:0] wr_row, wr_col;
  logic wr_en, scan_done, hit, hit_pel;
  logic [SCORE_W:0] sum;
  tile_t pac, disp;
  assign pac = '{row: pac_row, col: pac_col};
  assign disp = '{row: disp_row, col: disp_col};
  dot_init_scan u_scan (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (new_level),
    .en     (!new_level && (state_q == INIT_ADDR || state_q == INIT_SCAN)),
    .rd_row (wall_row),
    .rd_col (wall_col),
    .wr_row (wr_row),
    .wr_col (wr_col),
    .wr_en  (wr_en),
    .done   (scan_done)
  );
  assign hit = pac_valid && state_q == RUN && in_maze(pac) && map_q[pac_row][pac_col];
  assign hit_pel = is_pellet_tile(pac);
  assign sum = {1'b0, score_q} + (SCORE_W + 1)'(hit_pel ? PELLET_POINTS : DOT_POINTS);
  always_comb begin
    state_d = state_q;
    map_d = map_q;
    dots_d = dots_q;
    score_d = score_q;
    dot_d = 1'b0;
    pel_d = 1'b0;
    clr_d = 1'b0;
    if (new_level) begin
      state_d = INIT_ADDR;
    end else if (state_q == INIT_ADDR) begin
      state_d = INIT_SCAN;
      dots_d = '0;
      map_d = '{default: '0};
    end else if (state_q == INIT_SCAN && wr_en) begin
      map_d[wr_row][wr_col] = !wall_is_wall;
      dots_d = dots_q + {9'd0, !wall_is_wall};
      state_d = scan_done ? RUN : INIT_SCAN;
    end else if (hit) begin
      map_d[pac_row][pac_col] = 1'b0;
      dots_d = dots_q - 10'd1;
      score_d = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
      dot_d = !hit_pel;
      pel_d = hit_pel;
      clr_d = dots_q == 10'd1;
      state_d = dots_q == 10'd1 ? CLEARED : RUN;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= INIT_ADDR;
      map_q <= '{default: '0};
      dots_q <= '0;
      score_q <= '0;
      dot_q <= 1'b0;
      pel_q <= 1'b0;
      clr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      map_q <= map_d;
      dots_q <= dots_d;
      score_q <= score_d;
      dot_q <= dot_d;
      pel_q <= pel_d;
      clr_q <= clr_d;
    end
  end
  assign ready = state_q == RUN || state_q == CLEARED;
  assign dot_eaten = dot_q;
  assign pellet_eaten = pel_q;
  assign level_clear = clr_q;
  assign score = score_q;
  assign dots_left = dots_q;
  assign disp_dot = ready && in_maze(disp) && map_q[disp_row][disp_col];
  assign disp_pellet = disp_dot && is_pellet_tile(disp);
endmodule

// File: tb/tb_dot_eater.sv
// tb_dot_eater: randomized eating against a tile-map/score reference model, with a registered wall ROM stub.
module tb_dot_eater;
  logic clk = 0, reset_n = 0, new_level = 0, pac_valid = 0, wall_is_wall = 1;
  logic [4:0] pac_row = 0, pac_col = 0, disp_row = 0, disp_col = 0, wall_row, wall_col;
  logic disp_dot, disp_pellet, ready, dot_eaten, pellet_eaten, level_clear;
  logic [19:0] score;
  logic [9:0] dots_left;
  logic rom [31][28];
  logic exp_map [31][28];
  int exp_score = 0, exp_dots = 0, n_chk = 0, n_pass = 0;
  bit exp_ready = 0, exp_run = 0;

  dot_eater dut (
    .clk(clk), .reset_n(reset_n), .new_level(new_level), .pac_valid(pac_valid),
    .pac_row(pac_row), .pac_col(pac_col), .wall_row(wall_row), .wall_col(wall_col),
    .wall_is_wall(wall_is_wall), .disp_row(disp_row), .disp_col(disp_col),
    .disp_dot(disp_dot), .disp_pellet(disp_pellet), .ready(ready), .dot_eaten(dot_eaten),
    .pellet_eaten(pellet_eaten), .level_clear(level_clear), .score(score), .dots_left(dots_left)
  );

  always #5 clk = ~clk;
  always @(posedge clk) wall_is_wall <= (wall_row < 31 && wall_col < 28) ? rom[wall_row][wall_col] : 1'b1;

  task automatic check(string tag, int got, int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit pellet_at(int r, int c);
    return (r == 3 || r == 23) && (c == 1 || c == 26);
  endfunction

  task automatic set_rom(int mode);
    for (int r = 0; r < 31; r++)
      for (int c = 0; c < 28; c++)
        rom[r][c] = mode == 0 ? 1'b0 : mode == 1 ? (r == 0) : mode == 2 ? !(r == 10 && c == 10)
                  : ($urandom_range(0, 3) == 0);
  endtask

  task automatic load_model();
    exp_dots = 0;
    for (int r = 0; r < 31; r++)
      for (int c = 0; c < 28; c++) begin
        exp_map[r][c] = !rom[r][c];
        if (!rom[r][c]) exp_dots++;
      end
    exp_ready = 1;
    exp_run = 1;
  endtask

  task automatic wait_ready(string tag, int done_edges, int expect_edges);
    int n = done_edges;
    while (!ready && n < 2000) begin
      tick();
      n++;
    end
    check(tag, n, expect_edges);
    load_model();
    check({tag, "_dots"}, dots_left, exp_dots);
    check({tag, "_score"}, score, exp_score);
  endtask

  task automatic begin_level(int mode);
    set_rom(mode);
    new_level = 1;
    tick();
    new_level = 0;
    exp_ready = 0;
    exp_run = 0;
    check("nl_ready", ready, 0);
  endtask

  task automatic eat(int r, int c);
    bit h, pel;
    pel = pellet_at(r, c);
    h = 0;
    if (r < 31 && c < 28 && exp_ready && exp_run) h = exp_map[r][c];
    pac_valid = 1;
    pac_row = 5'(r);
    pac_col = 5'(c);
    tick();
    pac_valid = 0;
    if (h) begin
      exp_map[r][c] = 0;
      exp_dots--;
      exp_score = exp_score + (pel ? 50 : 10);
      if (exp_score > 20'hfffff) exp_score = 20'hfffff;
      if (exp_dots == 0) exp_run = 0;
    end
    check("dot_eaten", dot_eaten, int'(h && !pel));
    check("pellet_eaten", pellet_eaten, int'(h && pel));
    check("level_clear", level_clear, int'(h && exp_dots == 0));
    check("score", score, exp_score);
    if (exp_ready) check("dots_left", dots_left, exp_dots);
  endtask

  task automatic peek(int r, int c);
    bit e;
    e = 0;
    if (r < 31 && c < 28 && exp_ready) e = exp_map[r][c];
    disp_row = 5'(r);
    disp_col = 5'(c);
    #1;
    check("disp_dot", disp_dot, int'(e));
    check("disp_pellet", disp_pellet, int'(e && pellet_at(r, c)));
  endtask

  task automatic random_eats(int n);
    int r = 0, c = 0;
    for (int i = 0; i < n; i++) begin
      if (i % 3 != 2) begin
        r = $urandom_range(0, 31);
        c = $urandom_range(0, 31);
      end
      eat(r, c);
      if (i % 5 == 0) peek($urandom_range(0, 31), $urandom_range(0, 31));
    end
  endtask

  initial begin
    set_rom(0);
    repeat (3) tick();
    check("rst_ready", ready, 0);
    check("rst_score", score, 0);
    check("rst_dots", dots_left, 0);
    check("rst_wall_row", wall_row, 0);
    check("rst_wall_col", wall_col, 0);
    reset_n = 1;
    wait_ready("scan_len", 0, 869);
    check("open_dots", exp_dots, 868);
    peek(0, 0);
    peek(30, 27);
    peek(31, 0);
    peek(3, 1);
    eat(5, 5);
    eat(5, 5);
    eat(3, 26);
    peek(3, 26);
    random_eats(150);
    // new_level must win over a simultaneous eat
    set_rom(3);
    new_level = 1;
    pac_valid = 1;
    pac_row = 5'd7;
    pac_col = 5'd7;
    tick();
    new_level = 0;
    pac_valid = 0;
    exp_ready = 0;
    exp_run = 0;
    check("nl_ready", ready, 0);
    check("nl_score", score, exp_score);
    check("nl_dot_eaten", dot_eaten, 0);
    repeat (399) tick();
    eat(29, 27);
    wait_ready("rescan_len", 401, 870);
    random_eats(100);
    begin_level(1);
    wait_ready("row0_scan", 1, 870);
    check("row0_dots", exp_dots, 840);
    peek(0, 5);
    peek(1, 5);
    begin_level(0);
    repeat (400) tick();
    #3 reset_n = 0;
    #1;
    exp_score = 0;
    exp_ready = 0;
    check("ascan_ready", ready, 0);
    check("ascan_score", score, 0);
    check("ascan_dots", dots_left, 0);
    check("ascan_wall_row", wall_row, 0);
    check("ascan_wall_col", wall_col, 0);
    tick();
    reset_n = 1;
    wait_ready("rst_rescan", 0, 869);
    begin_level(2);
    wait_ready("one_scan", 1, 870);
    check("one_dots", exp_dots, 1);
    eat(10, 10);
    eat(5, 5);
    check("cleared_ready", ready, 1);
    peek(10, 10);
    begin_level(0);
    wait_ready("after_clear", 1, 870);
    random_eats(20);
    #3 reset_n = 0;
    #1;
    check("arun_ready", ready, 0);
    check("arun_score", score, 0);
    check("arun_dots", dots_left, 0);
    check("arun_dot_eaten", dot_eaten, 0);
    tick();
    reset_n = 1;
    tick();
    check("arun_rel_ready", ready, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
